// File: rtl/demux4_collector.sv
// Four-channel round-robin collector: merges din0..din3 into one registered
// output word tagged with its source index, using a valid/ready handshake on both sides.
module demux4_collector #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic [3:0]       vld,
  output logic [3:0]       rdy,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       sel,
  output logic             dout_vld,
  input  logic             dout_rdy
);

  logic [1:0]       last;
  logic [1:0]       grant;
  logic             found;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  assign load_en = !dout_vld || dout_rdy;

  // Search starts just past the last served channel; offset 4 wraps back to last itself.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    grant = 2'b00;
    idx   = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && vld[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Reset suppresses the grant so no source believes its word was taken.
  always_comb begin
    rdy = 4'b0000;
    if (!rst && load_en && found) rdy = 4'b0001 << grant;
  end

  assign xfer = |(vld & rdy);

  always_comb begin
    grant_data = din0;
    case (grant)
      2'd0: grant_data = din0;
      2'd1: grant_data = din1;
      2'd2: grant_data = din2;
      2'd3: grant_data = din3;
      default: grant_data = din0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      sel      <= 2'b00;
      dout_vld <= 1'b0;
      last     <= 2'b11;
    end else if (xfer) begin
      dout     <= grant_data;
      sel      <= grant;
      dout_vld <= 1'b1;
      last     <= grant;
    end else if (dout_vld && dout_rdy) begin
      dout_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux4_collector.sv
// Bench for demux4_collector: directed vector table for the corner sequences,
// then randomized traffic checked against a round-robin reference model.
module tb_demux4_collector;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din [4];
  logic [3:0]   vld;
  logic [3:0]   rdy;
  logic [W-1:0] dout;
  logic [1:0]   sel;
  logic         dout_vld;
  logic         dout_rdy;

  demux4_collector #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .din0     (din[0]),
    .din1     (din[1]),
    .din2     (din[2]),
    .din3     (din[3]),
    .vld      (vld),
    .rdy      (rdy),
    .dout     (dout),
    .sel      (sel),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int           m_last;
  logic         m_vld;
  logic [W-1:0] m_dout;
  logic [1:0]   m_sel;
  int           m_g;

  typedef struct {
    logic         rst;
    logic [3:0]   vld;
    logic         drdy;
    logic [3:0]   e_rdy;
    logic         e_vld;
    logic [1:0]   e_sel;
    logic [W-1:0] e_dout;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int from);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check rdy before the edge, advance the model at the edge,
  // check registered outputs just after it.
  task automatic cycle(input bit use_tab, input vec_t t, input string tag);
    logic [W-1:0] d [4];
    logic [3:0]   m_rdy;
    @(negedge clk);
    m_g = -1;
    if (!rst && (!m_vld || dout_rdy)) m_g = pick(vld, m_last);
    m_rdy = (m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
    chk({tag, " rdy"}, int'(rdy), use_tab ? int'(t.e_rdy) : int'(m_rdy));
    for (int n = 0; n < 4; n++) d[n] = din[n];
    @(posedge clk);
    if (rst) begin
      m_dout = '0; m_sel = 2'b00; m_vld = 1'b0; m_last = 3;
    end else if (m_g >= 0) begin
      m_dout = d[m_g]; m_sel = 2'(m_g); m_vld = 1'b1; m_last = m_g;
    end else if (m_vld && dout_rdy) begin
      m_vld = 1'b0;
    end
    #1;
    chk({tag, " dout_vld"}, int'(dout_vld), use_tab ? int'(t.e_vld)  : int'(m_vld));
    chk({tag, " sel"},      int'(sel),      use_tab ? int'(t.e_sel)  : int'(m_sel));
    chk({tag, " dout"},     int'(dout),     use_tab ? int'(t.e_dout) : int'(m_dout));
  endtask

  function automatic void add(input logic r, input logic [3:0] v, input logic dr,
                              input logic [3:0] er, input logic ev, input logic [1:0] es,
                              input logic [W-1:0] ed);
    vec_t x;
    x.rst = r; x.vld = v; x.drdy = dr; x.e_rdy = er; x.e_vld = ev; x.e_sel = es; x.e_dout = ed;
    tab.push_back(x);
  endfunction

  initial begin
    vec_t dummy;
    dummy = '{default: '0};
    m_last = 3; m_vld = 1'b0; m_dout = '0; m_sel = 2'b00; m_g = -1;
    rst = 1'b1; vld = 4'b0000; dout_rdy = 1'b0;
    for (int n = 0; n < 4; n++) din[n] = 8'hA0 + 8'(n);

    // Reset held two cycles with all channels requesting
    add(1, 4'hF, 0, 4'b0000, 0, 2'd0, 8'h00);
    add(1, 4'hF, 0, 4'b0000, 0, 2'd0, 8'h00);
    // Round-robin, full throughput
    add(0, 4'hF, 1, 4'b0001, 1, 2'd0, 8'hA0);
    add(0, 4'hF, 1, 4'b0010, 1, 2'd1, 8'hA1);
    add(0, 4'hF, 1, 4'b0100, 1, 2'd2, 8'hA2);
    add(0, 4'hF, 1, 4'b1000, 1, 2'd3, 8'hA3);
    add(0, 4'hF, 1, 4'b0001, 1, 2'd0, 8'hA0);
    add(0, 4'hF, 1, 4'b0010, 1, 2'd1, 8'hA1);
    add(0, 4'hF, 1, 4'b0100, 1, 2'd2, 8'hA2);
    add(0, 4'hF, 1, 4'b1000, 1, 2'd3, 8'hA3);
    // Fill with ch1, then backpressure for five cycles
    add(0, 4'b0010, 1, 4'b0010, 1, 2'd1, 8'hA1);
    for (int i = 0; i < 5; i++) add(0, 4'hF, 0, 4'b0000, 1, 2'd1, 8'hA1);
    add(0, 4'hF, 1, 4'b0100, 1, 2'd2, 8'hA2);
    // Sparse requests alternate between ch0 and ch3, then drain
    add(0, 4'b0001, 1, 4'b0001, 1, 2'd0, 8'hA0);
    add(0, 4'b1001, 1, 4'b1000, 1, 2'd3, 8'hA3);
    add(0, 4'b1001, 1, 4'b0001, 1, 2'd0, 8'hA0);
    add(0, 4'b1001, 1, 4'b1000, 1, 2'd3, 8'hA3);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd3, 8'hA3);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd3, 8'hA3);
    // Reset while a word is stalled
    add(0, 4'b0100, 0, 4'b0100, 1, 2'd2, 8'hA2);
    add(0, 4'hF,    0, 4'b0000, 1, 2'd2, 8'hA2);
    add(1, 4'hF,    0, 4'b0000, 0, 2'd0, 8'h00);
    add(0, 4'hF,    1, 4'b0001, 1, 2'd0, 8'hA0);
    // Single active channel granted every cycle
    add(0, 4'b0100, 1, 4'b0100, 1, 2'd2, 8'hA2);
    add(0, 4'b0100, 1, 4'b0100, 1, 2'd2, 8'hA2);
    add(0, 4'b0100, 1, 4'b0100, 1, 2'd2, 8'hA2);

    foreach (tab[i]) begin
      rst = tab[i].rst; vld = tab[i].vld; dout_rdy = tab[i].drdy;
      cycle(1'b1, tab[i], $sformatf("vec%0d", i));
    end

    // Hand sequence: stall, then consume and load at the same edge keeps dout_vld high
    rst = 1'b0; vld = 4'b0001; dout_rdy = 1'b0; din[0] = 8'h5C;
    cycle(1'b0, dummy, "hs_stall");
    din[1] = 8'h3E; vld = 4'b0010; dout_rdy = 1'b1;
    cycle(1'b0, dummy, "hs_swap");
    chk("hs_swap word", int'(dout), 32'h3E);

    // Randomized traffic; a requesting source holds its word until granted
    rst = 1'b1; vld = 4'b0000; dout_rdy = 1'b0;
    cycle(1'b0, dummy, "rnd_rst");
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      cycle(1'b0, dummy, "rnd");
      for (int n = 0; n < 4; n++) begin
        if (m_g == n || !vld[n]) begin
          vld[n] = ($urandom_range(0, 99) < 55);
          din[n] = W'($urandom);
        end
      end
      dout_rdy = ($urandom_range(0, 99) < 70);
      rst = ($urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux4_collector.md
Name: demux4_collector

Overview:
- 4-to-1 registered collector: the inverse of the team's 1-to-4 sel-steered demux.
- Accepts data from four independent source channels (din0..din3) and merges them onto a single output stream.
- Each output word is tagged with sel, the 2-bit index of the originating channel, so a downstream 1-to-4 demux can re-steer it.
- Round-robin arbitration between channels; single output holding register with valid/ready handshake.
- Sits between four producers and one shared serial consumer.

Parameters:
WIDTH, 1, data width of every din channel and of dout

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
din0  input  WIDTH  channel 0 data
din1  input  WIDTH  channel 1 data
din2  input  WIDTH  channel 2 data
din3  input  WIDTH  channel 3 data
vld  input  4  per-channel valid, bit N belongs to dinN
rdy  output  4  per-channel ready, bit N belongs to dinN; combinational
dout  output  WIDTH  registered merged data
sel  output  2  registered source index of dout (00..11)
dout_vld  output  1  dout/sel hold a valid word
dout_rdy  input  1  consumer accepts word when dout_vld=1

Behaviour:
- Reset (rst=1 at clk edge): dout=0, sel=2'b00, dout_vld=0, rr pointer last=2'b11, so channel 0 has first priority. rst overrides all other activity, including a pending handshake mid-transfer; the held word is discarded.
- load_en = !dout_vld | dout_rdy (combinational): the output register is empty or is being emptied this cycle.
- Arbitration (combinational):
  - Search vld starting at index last+1, wrapping modulo 4 (last=3 -> start at 0).
  - The first set bit is grant g.
  - rdy = onehot(g) when load_en=1 and any vld bit is set; otherwise rdy=4'b0000.
  - At most one rdy bit is ever high.
  - rdy must not depend on dout_vld/dout_rdy beyond load_en, and never on the vld of a non-granted channel after grant.
- Transfer on channel N: vld[N] & rdy[N] at a rising edge. Next cycle: dout=dinN, sel=N, dout_vld=1, last=N.
- Latency: source handshake at edge k -> word visible on dout at k (registered), i.e. available to the consumer in the cycle after acceptance.
- Consumer handshake: dout_vld & dout_rdy at an edge consumes the word.
  - If no new transfer happens at the same edge, dout_vld->0; dout and sel keep their last values.
- Simultaneous consume and load at one edge: the new word replaces the old one, and dout_vld stays 1. This gives full throughput of one word/cycle.
- Backpressure: while dout_vld=1 & dout_rdy=0, dout, sel and dout_vld are held stable, rdy=0000, and last is unchanged.
- No requests (vld=0000): no transfer, last unchanged.
- Fairness: with all four vld held high and dout_rdy=1, the grant order is 0,1,2,3,0,...
  - Each channel is served at most once per four grants while others wait.
- Single active channel: it is granted every cycle regardless of last.
- Sources must hold dinN/vld[N] until granted; the block does not sample non-granted data.
- Bit-exact: dout equals dinN exactly (no transformation); sel width is fixed at 2.

Test Plan:
- Reset: assert rst 2 cycles with vld=1111 -> dout_vld=0, dout=0, sel=00, rdy=0000 during reset; first grant after release is rdy=0001.
- Single channel: WIDTH=1, vld=0100, din2=1, dout_rdy=1 -> rdy=0100 each cycle; next cycle dout=1, sel=10, dout_vld=1; sustained 1 word/cycle.
- Round-robin: vld=1111, dout_rdy=1, 8 cycles -> sel sequence 00,01,10,11,00,01,10,11 on consecutive cycles.
- Backpressure: fill output with ch1 word, dout_rdy=0 for 5 cycles with vld=1111 -> dout/sel=01 stable, rdy=0000, dout_vld=1. Then dout_rdy=1 -> next grant is ch2, sel=10.
- Sparse requests: vld=1001 after ch0 granted -> next grant ch3 (sel=11), then ch0, alternating; vld=0000 -> dout_vld drops to 0 one edge after the last consume.
- Reset mid-operation: dout_vld=1 with dout_rdy=0, assert rst -> dout_vld=0, last=11. After release with vld=1111, first sel=00.
